// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding and default timing.
// Lets the wrapper and bench agree on state values and default hold/stagger lengths.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } seq_state_e;

   localparam int DEF_NUM_CH         = 3;
   localparam int DEF_CNT_W          = 12;
   localparam int DEF_HOLD_CYCLES    = 4095;
   localparam int DEF_STAGGER_CYCLES = 16;

endpackage

// File: rtl/reset_seq_counter.sv
// Shared up-counter for the hold and stagger intervals.
// Clear has priority over enable; at_term flags the current count equal to term.
module reset_seq_counter
   import reset_sequencer_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             at_term
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_term = (cnt_q == term);

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: common hold, then staggered per-channel release,
// with masked software re-reset and a registered pad output-enable force flag.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_CH         = DEF_NUM_CH,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sw_rst_req,
   input  logic [NUM_CH-1:0] sw_rst_mask,
   output logic [NUM_CH-1:0] rst_n_o,
   output logic              pad_oeb_force,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   seq_state_e        state_d, state_q;
   logic [NUM_CH-1:0] pend_d, pend_q;
   logic [IDX_W-1:0]  idx_d, idx_q;
   logic [NUM_CH-1:0] rst_n_d, rst_n_q;
   logic              pad_d, pad_q;
   logic              busy_d, busy_q;
   logic              done_d, done_q;

   logic              cnt_clr;
   logic              cnt_en;
   logic              at_term;
   logic [CNT_W-1:0]  term;
   logic              req;
   logic [NUM_CH-1:0] rel_onehot;

   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
      lowest_set = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = IDX_W'(i);
      end
   endfunction

   assign term       = (state_q == ST_HOLD) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(STAGGER_CYCLES - 1);
   assign req        = sw_rst_req && (sw_rst_mask != '0);
   assign rel_onehot = NUM_CH'(1) << idx_q;

   reset_seq_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .term    (term),
      .at_term (at_term)
   );

   // A request pre-empts any release due on the same edge; in RUN pend is
   // already empty, so the OR collapses to the mask itself.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      rst_n_d = rst_n_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      if (req) begin
         pend_d  = pend_q | sw_rst_mask;
         rst_n_d = rst_n_q & ~sw_rst_mask;
         state_d = ST_HOLD;
         cnt_clr = 1'b1;
      end else if (state_q != ST_RUN) begin
         if (at_term) begin
            rst_n_d = rst_n_q | rel_onehot;
            pend_d  = pend_q & ~rel_onehot;
            cnt_clr = 1'b1;
            state_d = (pend_d == '0) ? ST_RUN : ST_RELEASE;
         end else begin
            cnt_en = 1'b1;
         end
      end
      idx_d  = lowest_set(pend_d);
      pad_d  = ~rst_n_d[0];
      done_d = (state_d == ST_RUN);
      busy_d = ~done_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HOLD;
         pend_q  <= '1;
         idx_q   <= '0;
         rst_n_q <= '0;
         pad_q   <= 1'b1;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         idx_q   <= idx_d;
         rst_n_q <= rst_n_d;
         pad_q   <= pad_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign rst_n_o       = rst_n_q;
   assign pad_oeb_force = pad_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random requests, checked
// against a release-schedule model through an expected-output queue.
module tb_reset_sequencer;
   import reset_sequencer_pkg::*;

   localparam int NUM_CH  = 3;
   localparam int HOLD    = 8;
   localparam int STAGGER = 4;
   localparam int W       = NUM_CH + 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sw_rst_req = 1'b0;
   logic [NUM_CH-1:0] sw_rst_mask = '0;
   logic [NUM_CH-1:0] rst_n_o;
   logic              pad_oeb_force;
   logic              busy;
   logic              done;
   logic [1:0]        dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];

   // Reference model: absolute edge at which each channel is due to release (-1 = none).
   int                now = 0;
   int                rel_at[NUM_CH];
   logic [NUM_CH-1:0] m_out = '0;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_CH(NUM_CH), .CNT_W(12), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAGGER)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sw_rst_req    (sw_rst_req),
      .sw_rst_mask   (sw_rst_mask),
      .rst_n_o       (rst_n_o),
      .pad_oeb_force (pad_oeb_force),
      .busy          (busy),
      .done          (done),
      .dbg_state     (dbg_state)
   );

   function automatic logic [NUM_CH-1:0] model_pending();
      logic [NUM_CH-1:0] p;
      p = '0;
      for (int c = 0; c < NUM_CH; c++) if (rel_at[c] >= 0) p[c] = 1'b1;
      return p;
   endfunction

   // Channels in the set release in ascending order: first after the full hold,
   // each further one a stagger later, counted from the edge that started the hold.
   task automatic model_schedule(input logic [NUM_CH-1:0] set);
      int k;
      k = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (set[c]) begin
            rel_at[c] = now + HOLD + k * STAGGER;
            k++;
         end else begin
            rel_at[c] = -1;
         end
      end
   endtask

   task automatic model_edge(input logic r, input logic q, input logic [NUM_CH-1:0] mk);
      logic [NUM_CH-1:0] p;
      now++;
      if (r) begin
         m_out = '0;
         model_schedule('1);
      end else if (q && mk != '0) begin
         p = model_pending() | mk;
         m_out = m_out & ~mk;
         model_schedule(p);
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (rel_at[c] == now) begin
               m_out[c]  = 1'b1;
               rel_at[c] = -1;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic q, input logic [NUM_CH-1:0] mk);
      logic m_done;
      rst = r;
      sw_rst_req = q;
      sw_rst_mask = mk;
      @(posedge clk);
      model_edge(r, q, mk);
      m_done = (model_pending() == '0);
      exp_q.push_back({m_out, ~m_out[0], ~m_done, m_done});
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
   endtask

   // Monitor: one expected vector per clock edge, compared mid-cycle.
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] got;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {rst_n_o, pad_oeb_force, busy, done};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL outputs{rst_n,pad,busy,done} t=%0t got=%b exp=%b", $time, got, e);
         end
      end
   end

   initial begin
      for (int c = 0; c < NUM_CH; c++) rel_at[c] = -1;

      // Power-up sequence
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
      idle(20);
      // Re-reset from RUN with masks that keep / drop channel 0
      step(1'b0, 1'b1, 3'b110);
      idle(20);
      step(1'b0, 1'b1, 3'b101);
      idle(20);
      // Re-reset of channel 0 during the stagger gap after its release
      step(1'b1, 1'b0, '0);
      idle(HOLD + 1);
      step(1'b0, 1'b1, 3'b001);
      idle(25);
      // rst two cycles into a stagger gap
      step(1'b1, 1'b0, '0);
      idle(HOLD + STAGGER + 2);
      step(1'b1, 1'b0, '0);
      idle(20);
      // Zero-mask requests in HOLD, RELEASE and RUN
      step(1'b1, 1'b0, '0);
      idle(3);
      step(1'b0, 1'b1, 3'b000);
      idle(HOLD + 1);
      step(1'b0, 1'b1, 3'b000);
      idle(12);
      step(1'b0, 1'b1, 3'b000);
      idle(3);
      // Request landing exactly on a release edge (edge HOLD after reset)
      step(1'b1, 1'b0, '0);
      idle(HOLD - 1);
      step(1'b0, 1'b1, 3'b011);
      idle(25);

      // Random traffic in bursts of varying request density
      for (int b = 0; b < 40; b++) begin
         int dens;
         dens = $urandom_range(3, 40);
         for (int i = 0; i < 60; i++) begin
            logic r, q;
            logic [NUM_CH-1:0] mk;
            r  = ($urandom_range(0, 249) == 0);
            q  = ($urandom_range(0, dens) == 0);
            mk = NUM_CH'($urandom);
            step(r, q, mk);
         end
      end
      idle(5);

      // Drain: bounded wait for the monitor to consume every expectation
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
